fetch_stage: RTL

//  Instruction-fetch stage: owns the program counter, drives the program-memory address,

---
 rtl/fetch_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, program-memory address and instruction register.
// Optional FETCH_PERF_EN adds saturating fetch/bubble counters.
module fetch_stage #(
  parameter int          ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INS  = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              stall_pm,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [31:0]       pm_data,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
`ifdef FETCH_PERF_EN
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       bubble_cnt,
`endif
  output logic [5:0]        op
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    unique case (1'b1)
      branch_en: begin
        // Redirect flushes the word fetched from the old path.
        pc_d       = branch_addr;
        ir_d       = NOP_INS;
        ir_valid_d = 1'b0;
      end
      default: begin
        if (!stall) begin
          pc_d = pc_q + 1'b1;
        end
        if (stall_pm) begin
          ir_d       = NOP_INS;
          ir_valid_d = 1'b0;
        end else begin
          ir_d       = pm_data;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INS;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign pm_addr  = pc_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign op       = ir_q[31:26];

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // Every non-reset edge loads either a real word or a bubble.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ir_valid_d) begin
      if (fetch_cnt_q != 16'hFFFF) begin
        fetch_cnt_d = fetch_cnt_q + 16'd1;
      end
    end else begin
      if (bubble_cnt_q != 16'hFFFF) begin
        bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
